pulse_gen: RTL and testbench
============================

# pulse_gen

Command-driven pulse-train generator that sits directly downstream of the Avalon-MM control-register slave. It consumes the slave's `start_comm`, `stop_comm`, `start_N_comm` and `pulse_invert_comm` outputs, together with period, high-time and count values held in register space. It produces a programmable pulse train on `pulse_out`, either free-running or a burst of N pulses, with selectable output polarity. Status outputs (`busy`, `done`, `pulses_sent`, `cfg_err`) are fed back to the slave's read path.

## Interface
- `CNT_W`, 16: width of the period and high-time counters.
- `NUM_W`, 16: width of the pulse count and the `pulses_sent` counter.

- `clk`  in  1  system clock; all flops are rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start_comm`  in  1  level; its rising edge starts continuous mode.
- `stop_comm`  in  1  level; its rising edge stops generation.
- `start_N_comm`  in  1  level; its rising edge starts an N-pulse burst.
- `pulse_invert_comm`  in  1  level; 1 selects inverted output polarity.
- `period`  in  CNT_W  pulse period in clk cycles.
- `high_len`  in  CNT_W  active-phase length in clk cycles.
- `n_pulses`  in  NUM_W  burst length for start_N.
- `pulse_out`  out  1  registered pulse output.
- `busy`  out  1  high while in RUN_CONT or RUN_N.
- `done`  out  1  one-cycle strobe when a burst completes.
- `pulses_sent`  out  NUM_W  count of completed periods since the last start.
- `cfg_err`  out  1  one-cycle strobe when a start is rejected.

## Operation
- **Edge detection.** Each command input has a previous-value register `*_d`. An edge is `cmd & ~cmd_d`, evaluated at each posedge. The `*_d` registers reset to 1, so a level held high through reset does not fire.
- **States.**
  - IDLE.
  - RUN_CONT: periodic pulses until stopped.
  - RUN_N: exactly `n_pulses` periods, then IDLE.
- **Priority for simultaneous edges:** stop > start_N > start.
- **Config latch.** On an accepted start, `period`, `high_len` and `n_pulses` are latched. Later changes to these inputs have no effect until the next start.
- **Validation.**
  - Conditions: `period==0`, `high_len==0`, or `high_len>=period`.
  - If any condition holds, the start is rejected: `cfg_err`=1 for one cycle, state stays or returns to IDLE, and `pulses_sent` is unchanged.
- **Empty burst.** start_N with a valid config and `n_pulses==0`: `done`=1 for one cycle, no pulse emitted, `pulses_sent` cleared, state stays IDLE.
- **Phase counter.**
  - Counts 0..period_l-1 and wraps to 0.
  - The raw pulse is 1 while phase < high_len_l.
  - `pulses_sent` increments (wrapping at 2^NUM_W) on each wrap.
- **Output.** `pulse_out` is registered: (raw & running) XOR inv. `inv` is `pulse_invert_comm` registered each cycle; polarity may change at any time, including mid-pulse. In IDLE, `pulse_out` = inv.
- **Start while running** (any start edge in RUN_*): retrigger. Config is re-latched, phase restarts at 0, `pulses_sent` is cleared, and the new mode is entered.
- **Stop.**
  - In RUN_*: immediate abort. Next state is IDLE, the current pulse is truncated, and `pulses_sent` holds its value. `done` is not asserted.
  - In IDLE: no effect.
- **Burst completion.** In RUN_N, when the wrap that makes `pulses_sent`==n_pulses_l occurs: state goes to IDLE and `done`=1 for that cycle.
- **Async reset mid-operation.** State IDLE, phase 0, all outputs at reset values. No `done`.

## Timing
- **Reset values:** `pulse_out`=0, `busy`=0, `done`=0, `pulses_sent`=0, `cfg_err`=0. After the first clock, `pulse_out` follows inv.
- **Start latency.** A command first sampled high at edge T:
  - At T: `busy`=1 and `pulse_out` goes active.
  - `pulse_out` is active for edges T..T+high_len-1 and idle for T+high_len..T+period-1.
  - The pattern repeats every `period` cycles exactly.
- **Pulse count.** `pulses_sent` becomes k at edge T+k·period.
- **Burst end.** The last edge of an N burst is T+N·period: `busy`=0, `done`=1, and `pulse_out` idle at that edge.
- **Stop latency.** A stop edge sampled at S gives `busy`=0 and `pulse_out`=inv at S.
- **Polarity latency.** A `pulse_invert_comm` change sampled at edge P affects `pulse_out` at edge P+1.
- **Strobe width.** `cfg_err` and `done` are exactly one cycle wide and are registered at the deciding edge.

## Test plan
- **Continuous mode.** Reset, then period=5, high_len=2, start_comm rising → `pulse_out` 1,1,0,0,0 repeating from edge T; `pulses_sent`=3 at T+15; stop_comm rising at T+16 → `pulse_out`=0 and `busy`=0 at that edge, `pulses_sent` holds 3.
- **Burst mode.** period=4, high_len=1, n_pulses=3, start_N_comm rising → 3 pulses; `done`=1 and `busy`=0 exactly at T+12, `pulses_sent`=3.
- **Config errors and empty burst.**
  - period=4, high_len=4, start → `cfg_err`=1 for one cycle, `busy` stays 0.
  - period=0 → same result.
  - n_pulses=0 start_N → `done`=1 for one cycle, no pulse.
- **Invert and reset held command.**
  - pulse_invert_comm=1 in IDLE → `pulse_out`=1 after 1 cycle.
  - Running period=4, high_len=2 with invert → pattern 0,0,1,1.
  - start_comm held high through reset → no start after reset.
- **Priority and retrigger.**
  - stop and start edges in the same cycle while running → IDLE.
  - start_N rising mid-burst with n_pulses=2 → phase restarts, `pulses_sent`=0, `done` at T'+2·period.
- **Asynchronous reset.** Assert `rst` mid-pulse, between clock edges → all outputs 0 immediately, no `done`; after release, a new start behaves normally.

Source files
------------

// File: rtl/pulse_gen.sv
// Command-driven pulse-train generator: free-running or N-pulse burst with
// selectable polarity, driven by edge-detected commands from the register slave.
module pulse_gen #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_comm,
  input  logic             stop_comm,
  input  logic             start_N_comm,
  input  logic             pulse_invert_comm,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] high_len,
  input  logic [NUM_W-1:0] n_pulses,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] pulses_sent,
  output logic             cfg_err
);

  typedef enum logic [1:0] {IDLE, RUN_CONT, RUN_N} state_t;

  state_t           r_state, w_state_nx;
  logic             r_start_d, r_stop_d, r_startn_d, r_inv;
  logic [CNT_W-1:0] r_period_l, r_high_l, r_phase;
  logic [CNT_W-1:0] w_period_nx, w_high_nx, w_phase_nx;
  logic [NUM_W-1:0] r_n_l, r_cnt, w_n_nx, w_cnt_nx, w_cnt_inc;
  logic             r_pulse, r_busy, r_done, r_err;
  logic             w_start_e, w_stop_e, w_startn_e, w_cfg_ok;
  logic             w_running, w_wrap, w_done_nx, w_err_nx, w_pulse_nx;

  assign w_start_e  = start_comm & ~r_start_d;
  assign w_stop_e   = stop_comm & ~r_stop_d;
  assign w_startn_e = start_N_comm & ~r_startn_d;
  assign w_cfg_ok   = (period != '0) && (high_len != '0) && (high_len < period);
  assign w_running  = (r_state != IDLE);
  assign w_wrap     = (r_phase == r_period_l - CNT_W'(1));
  assign w_cnt_inc  = r_cnt + NUM_W'(1);

  always_comb begin
    w_state_nx  = r_state;
    w_period_nx = r_period_l;
    w_high_nx   = r_high_l;
    w_n_nx      = r_n_l;
    w_phase_nx  = r_phase;
    w_cnt_nx    = r_cnt;
    w_done_nx   = 1'b0;
    w_err_nx    = 1'b0;
    if (w_stop_e) begin
      if (w_running) w_state_nx = IDLE;
    end else if (w_startn_e || w_start_e) begin
      if (!w_cfg_ok) begin
        w_err_nx   = 1'b1;
        w_state_nx = IDLE;
      end else begin
        w_period_nx = period;
        w_high_nx   = high_len;
        w_n_nx      = n_pulses;
        w_phase_nx  = '0;
        w_cnt_nx    = '0;
        if (w_startn_e) begin
          // A zero-length burst completes on the spot without emitting a pulse
          if (n_pulses == '0) begin
            w_done_nx  = 1'b1;
            w_state_nx = IDLE;
          end else begin
            w_state_nx = RUN_N;
          end
        end else begin
          w_state_nx = RUN_CONT;
        end
      end
    end else if (w_running) begin
      if (w_wrap) begin
        w_phase_nx = '0;
        w_cnt_nx   = w_cnt_inc;
        if ((r_state == RUN_N) && (w_cnt_inc == r_n_l)) begin
          w_state_nx = IDLE;
          w_done_nx  = 1'b1;
        end
      end else begin
        w_phase_nx = r_phase + CNT_W'(1);
      end
    end
    w_pulse_nx = ((w_phase_nx < w_high_nx) && (w_state_nx != IDLE)) ^ r_inv;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_start_d  <= 1'b1;
      r_stop_d   <= 1'b1;
      r_startn_d <= 1'b1;
      r_inv      <= 1'b0;
      r_period_l <= '0;
      r_high_l   <= '0;
      r_n_l      <= '0;
      r_phase    <= '0;
      r_cnt      <= '0;
      r_pulse    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_start_d  <= start_comm;
      r_stop_d   <= stop_comm;
      r_startn_d <= start_N_comm;
      r_inv      <= pulse_invert_comm;
      r_period_l <= w_period_nx;
      r_high_l   <= w_high_nx;
      r_n_l      <= w_n_nx;
      r_phase    <= w_phase_nx;
      r_cnt      <= w_cnt_nx;
      r_pulse    <= w_pulse_nx;
      r_busy     <= (w_state_nx != IDLE);
      r_done     <= w_done_nx;
      r_err      <= w_err_nx;
    end
  end

  assign pulse_out   = r_pulse;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pulses_sent = r_cnt;
  assign cfg_err     = r_err;

endmodule

// File: tb/tb_pulse_gen.sv
// Scoreboard bench for pulse_gen: a timing-rule model predicts every clock edge,
// a separate monitor pops and compares the registered outputs.
module tb_pulse_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_comm = 1'b0, stop_comm = 1'b0, start_N_comm = 1'b0, pulse_invert_comm = 1'b0;
  logic [15:0] period = '0, high_len = '0, n_pulses = '0;
  logic        pulse_out, busy, done, cfg_err;
  logic [15:0] pulses_sent;

  typedef struct packed {
    logic        pulseOut;
    logic        busy;
    logic        done;
    logic [15:0] pulsesSent;
    logic        cfgErr;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   fails = 0;

  // Stimulus levels and model state
  bit sS = 1'b0, sP = 1'b0, sN = 1'b0, sI = 1'b0;
  int sPer = 0, sHi = 0, sNum = 0;
  bit pS = 1'b1, pP = 1'b1, pN = 1'b1, mInv = 1'b0, mRun = 1'b0, mModeN = 1'b0;
  int mCyc = 0, mT = 0, mPer = 1, mHi = 0, mN = 0, mHeld = 0;

  pulse_gen #(.CNT_W(16), .NUM_W(16)) dut (
    .clk(clk), .rst(rst),
    .start_comm(start_comm), .stop_comm(stop_comm),
    .start_N_comm(start_N_comm), .pulse_invert_comm(pulse_invert_comm),
    .period(period), .high_len(high_len), .n_pulses(n_pulses),
    .pulse_out(pulse_out), .busy(busy), .done(done),
    .pulses_sent(pulses_sent), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input exp_t e);
    exp_t a;
    a = '{pulseOut: pulse_out, busy: busy, done: done, pulsesSent: pulses_sent, cfgErr: cfg_err};
    checks++;
    if (a !== e) begin
      fails++;
      $display("[TB] FAIL %s t=%0t: got pulse=%b busy=%b done=%b sent=%0d err=%b, expected pulse=%b busy=%b done=%b sent=%0d err=%b",
               name, $time, a.pulseOut, a.busy, a.done, a.pulsesSent, a.cfgErr,
               e.pulseOut, e.busy, e.done, e.pulsesSent, e.cfgErr);
    end
  endtask

  // Expected outputs at the next edge, from start time, period and burst length
  task automatic modelEdge();
    bit   eS, eP, eN;
    exp_t e;
    int   t;
    mCyc++;
    t  = mCyc;
    eS = sS & ~pS;
    eP = sP & ~pP;
    eN = sN & ~pN;
    e  = '0;
    if (eP) begin
      if (mRun) begin
        mHeld = (t - 1 - mT) / mPer;
        mRun  = 1'b0;
      end
    end else if (eN || eS) begin
      if (sPer == 0 || sHi == 0 || sHi >= sPer) begin
        e.cfgErr = 1'b1;
        if (mRun) begin
          mHeld = (t - 1 - mT) / mPer;
          mRun  = 1'b0;
        end
      end else begin
        mT = t; mPer = sPer; mHi = sHi; mN = sNum;
        if (eN && sNum == 0) begin
          e.done = 1'b1;
          mHeld  = 0;
          mRun   = 1'b0;
        end else begin
          mRun   = 1'b1;
          mModeN = eN;
        end
      end
    end else if (mRun && mModeN && (t - mT) == mN * mPer) begin
      e.done = 1'b1;
      mHeld  = mN;
      mRun   = 1'b0;
    end
    if (mRun) begin
      e.busy       = 1'b1;
      e.pulsesSent = 16'((t - mT) / mPer);
      e.pulseOut   = ((((t - mT) % mPer) < mHi) ? 1'b1 : 1'b0) ^ mInv;
    end else begin
      e.pulsesSent = 16'(mHeld);
      e.pulseOut   = mInv;
    end
    mInv = sI;
    pS = sS; pP = sP; pN = sN;
    expQ.push_back(e);
  endtask

  task automatic resetModel();
    mRun = 1'b0; mHeld = 0; mInv = 1'b0;
    pS = 1'b1; pP = 1'b1; pN = 1'b1;
  endtask

  // Called 2 units after a posedge; drives one cycle and returns at the same phase
  task automatic applyStimulus();
    start_comm = sS; stop_comm = sP; start_N_comm = sN; pulse_invert_comm = sI;
    period = 16'(sPer); high_len = 16'(sHi); n_pulses = 16'(sNum);
    modelEdge();
    @(posedge clk);
    #2;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1 checkOutput("async_reset", '0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 checkOutput("reset_hold", '0);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    resetModel();
  endtask

  // Monitor: every edge that has a prediction is compared
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) checkOutput("edge", expQ.pop_front());
    end
  end

  initial begin
    sS = 1'b1;
    start_comm = 1'b1;
    #1 checkOutput("reset_state", '0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    resetModel();
    hold(3);
    sS = 0; hold(1);

    sPer = 5; sHi = 2; sS = 1; hold(16);
    sP = 1; hold(3);
    sS = 0; sP = 0; hold(1);

    sPer = 4; sHi = 1; sNum = 3; sN = 1; hold(14);
    sN = 0; hold(1);

    sHi = 4; sS = 1; hold(2); sS = 0; hold(1);
    sPer = 0; sHi = 1; sS = 1; hold(2); sS = 0; hold(1);
    sPer = 4; sHi = 1; sNum = 0; sN = 1; hold(3); sN = 0; hold(1);

    sI = 1; hold(2);
    sPer = 4; sHi = 2; sS = 1; hold(9);
    sI = 0; hold(3);
    sP = 1; hold(2); sS = 0; sP = 0; hold(1);

    sS = 1; hold(3); sS = 0; hold(1);
    sS = 1; sP = 1; hold(3); sS = 0; sP = 0; hold(1);

    sNum = 3; sN = 1; hold(5); sN = 0; hold(1);
    sNum = 2; sN = 1; hold(10); sN = 0; hold(1);

    sS = 1; hold(2); sPer = 7; sHi = 3; hold(10);
    sP = 1; hold(1); sS = 0; sP = 0; hold(1);

    sPer = 6; sHi = 3; sS = 1; hold(2);
    sS = 0;
    doReset();
    hold(1); sS = 1; hold(8); sP = 1; hold(1); sS = 0; sP = 0; hold(1);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(11) == 0) sS = ~sS;
      if ($urandom_range(11) == 0) sN = ~sN;
      if ($urandom_range(23) == 0) sP = ~sP;
      if ($urandom_range(15) == 0) sI = ~sI;
      if ($urandom_range(7) == 0) begin
        sPer = $urandom_range(7);
        sHi  = $urandom_range(7);
        sNum = $urandom_range(4);
      end
      applyStimulus();
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (expQ.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain: got %0d pending predictions, expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
